fft_stream_ctrl: RTL

FFT_STREAM_CTRL -- requirements
Module: fft_stream_ctrl

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_frame_buf.sv | 33 +++
 rtl/fft_stream_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample types, controller state encoding and the bit-reverse helper
// for the streaming FFT frame controller.
package fft_pkg;

  // Default frame geometry: 2**4 = 16 complex points, 16-bit two's-complement components.
  localparam int DEF_POINT_FFT_POW2 = 4;
  localparam int DEF_POINT_FFT      = 1 << DEF_POINT_FFT_POW2;
  localparam int DEF_FRAC_BITS      = 15;

  // One complex sample laid out as on the ports: [0] = Re, [1] = Im.
  typedef logic [1:0][DEF_FRAC_BITS:0] cplx_t;
  // A whole frame as presented to / returned from the FFT datapath.
  typedef cplx_t [DEF_POINT_FFT-1:0] frame_t;

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StSettle = 2'd1,
    StUnload = 2'd2
  } fft_state_e;

  // Reverse the low 'width' bits of 'val'; bits above 'width' come back as zero.
  function automatic logic [15:0] bit_rev(input logic [15:0] val, input int width);
    logic [15:0] res;
    logic [15:0] src;
    res = '0;
    src = val;
    for (int i = 0; i < 16; i++) begin
      if (i < width) begin
        res = {res[14:0], src[0]};
        src = {1'b0, src[15:1]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Frame-wide complex register file. One write port with a per-entry enable, so the same
// port serves single-sample streaming writes and whole-frame captures; every entry is
// readable in parallel.
module fft_frame_buf import fft_pkg::*; #(
  parameter  int ADDR_W    = DEF_POINT_FFT_POW2,
  parameter  int FRAC_BITS = DEF_FRAC_BITS,
  localparam int DEPTH     = 1 << ADDR_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [DEPTH-1:0]                    wr_en_i,
  input  logic [DEPTH-1:0][1:0][FRAC_BITS:0]  wr_data_i,
  output logic [DEPTH-1:0][1:0][FRAC_BITS:0]  rd_data_o
);

  logic [DEPTH-1:0][1:0][FRAC_BITS:0] mem_q;

  // Storage: cleared by reset, each enabled entry takes its slice of the write data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_i[i]) begin
          mem_q[i] <= wr_data_i[i];
        end
      end
    end
  end

  assign rd_data_o = mem_q;

endmodule

// File: rtl/fft_stream_ctrl.sv
// Streaming front/back end for a combinational FFT datapath. Collects one frame of complex
// samples, holds it on fft_data_o while the external datapath settles, captures the result
// and streams the bins out in natural order (results are read bit-reversed). Single buffered:
// a new frame is accepted only after the previous one has been fully unloaded.
module fft_stream_ctrl import fft_pkg::*; #(
  parameter  int POINT_FFT_POW2 = DEF_POINT_FFT_POW2,
  parameter  int FRAC_BITS      = DEF_FRAC_BITS,
  // Legal range 1..15; the settle counter is 4 bits wide.
  parameter  int SETTLE_CYCLES  = 1,
  localparam int POINT_FFT      = 1 << POINT_FFT_POW2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic [1:0][FRAC_BITS:0]                 in_data_i,
  input  logic                                    in_last_i,
  output logic [POINT_FFT-1:0][1:0][FRAC_BITS:0]  fft_data_o,
  input  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0]  fft_data_i,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic [1:0][FRAC_BITS:0]                 out_data_o,
  output logic [POINT_FFT_POW2-1:0]               out_index_o,
  output logic                                    out_last_o,
  output logic                                    busy_o,
  output logic                                    frame_err_o
);

  localparam logic [POINT_FFT_POW2-1:0] LastIdx    = {POINT_FFT_POW2{1'b1}};
  localparam logic [3:0]                SettleLast = 4'(SETTLE_CYCLES - 1);

  fft_state_e                  state_q, state_d;
  logic [POINT_FFT_POW2-1:0]   wr_cnt_q, wr_cnt_d;
  logic [POINT_FFT_POW2-1:0]   rd_cnt_q, rd_cnt_d;
  logic [3:0]                  settle_cnt_q, settle_cnt_d;
  logic                        err_q, err_d;

  logic                                   in_accept;
  logic                                   capture;
  logic [POINT_FFT-1:0]                   in_wr_en;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] in_wr_data;
  logic [POINT_FFT-1:0]                   res_wr_en;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] res_data;
  logic [POINT_FFT_POW2-1:0]              rd_addr;

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StLoad;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      settle_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_d        = err_q;
    in_ready_o   = 1'b0;
    in_accept    = 1'b0;
    out_valid_o  = 1'b0;
    capture      = 1'b0;

    unique case (state_q)
      StLoad: begin
        // Reset is asynchronous to the state register, so ready is gated directly.
        in_ready_o = ~rst_i;
        in_accept  = in_valid_i & ~rst_i;
        if (in_accept) begin
          if (wr_cnt_q == LastIdx) begin
            // A full frame is processed even when its final beat lacks in_last.
            wr_cnt_d = '0;
            state_d  = StSettle;
            if (!in_last_i) begin
              err_d = 1'b1;
            end
          end else if (in_last_i) begin
            // Short frame: drop it and restart from entry 0.
            wr_cnt_d = '0;
            err_d    = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          capture      = 1'b1;
          settle_cnt_d = '0;
          state_d      = StUnload;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      StUnload: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (rd_cnt_q == LastIdx) begin
            rd_cnt_d = '0;
            state_d  = StLoad;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // Buffer write enables: one entry per accepted beat, whole frame on capture.
  always_comb begin
    in_wr_data = {POINT_FFT{in_data_i}};
    in_wr_en   = '0;
    for (int i = 0; i < POINT_FFT; i++) begin
      in_wr_en[i] = in_accept && (wr_cnt_q == POINT_FFT_POW2'(i));
    end
    res_wr_en = {POINT_FFT{capture}};
  end

  fft_frame_buf #(
    .ADDR_W    (POINT_FFT_POW2),
    .FRAC_BITS (FRAC_BITS)
  ) u_in_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (in_wr_en),
    .wr_data_i (in_wr_data),
    .rd_data_o (fft_data_o)
  );

  fft_frame_buf #(
    .ADDR_W    (POINT_FFT_POW2),
    .FRAC_BITS (FRAC_BITS)
  ) u_res_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (res_wr_en),
    .wr_data_i (fft_data_i),
    .rd_data_o (res_data)
  );

  // Radix-2 results arrive bit-reversed; reverse the read address to emit natural order.
  assign rd_addr     = POINT_FFT_POW2'(bit_rev(16'(rd_cnt_q), POINT_FFT_POW2));
  assign out_data_o  = res_data[rd_addr];
  assign out_index_o = rd_cnt_q;
  assign out_last_o  = (state_q == StUnload) && (rd_cnt_q == LastIdx);
  assign busy_o      = (state_q != StLoad);
  assign frame_err_o = err_q;

endmodule
